// File: rtl/alu_pkg.sv
// Shared ALU control codes and the multiply/divide sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_DIV  = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (shift-add) and divide (restoring) unit producing HI/LO.
// Works on operand magnitudes and applies the result signs in a final fix-up cycle.
module mult_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  md_state_t state, state_next;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [5:0]         cnt;
  logic               neg_q, neg_rem, is_div;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  logic op_mult, op_div, accept, last_iter;
  assign op_mult   = (alu_control == ALU_MULT);
  assign op_div    = (alu_control == ALU_DIV);
  assign accept    = (state == S_IDLE) && start && (op_mult || op_div);
  assign last_iter = (cnt == 6'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && op_mult)     state_next = S_MUL;
        else if (start && op_div) state_next = (b == '0) ? S_DONE : S_DIV;
      end
      S_MUL:   if (last_iter) state_next = S_FIX;
      S_DIV:   if (last_iter) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign done = (state == S_DONE);

  // Multiply step: add multiplicand into the upper half when the low bit is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
  assign mul_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                           : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};

  // Divide step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  logic [WIDTH:0]     trial, diff;
  logic [2*WIDTH-1:0] div_step;
  assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = trial - {1'b0, mag_b};
  assign div_step = diff[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] fixed;
  always_comb begin
    fixed = neg_q ? -acc : acc;
    if (is_div) begin
      fixed[2*WIDTH-1:WIDTH] = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fixed[WIDTH-1:0]       = neg_q   ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_rem     <= 1'b0;
      is_div      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        mag_a       <= magnitude(a);
        mag_b       <= magnitude(b);
        neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
        neg_rem     <= a[WIDTH-1];
        is_div      <= op_div;
        cnt         <= '0;
        div_by_zero <= 1'b0;
        acc         <= {{WIDTH{1'b0}}, op_div ? magnitude(a) : magnitude(b)};
        if (op_div && (b == '0)) begin
          hi          <= a;
          lo          <= '1;
          div_by_zero <= 1'b1;
        end
      end
      if (state == S_MUL || state == S_DIV) begin
        acc <= (state == S_DIV) ? div_step : mul_step;
        cnt <= cnt + 6'd1;
      end
      // Results become visible in the DONE cycle.
      if (state == S_FIX) begin
        hi <= fixed[2*WIDTH-1:WIDTH];
        lo <= fixed[WIDTH-1:0];
      end
    end
  end

endmodule
